pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 111 +++++++++++
 tb/tb_pc_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : PC holder and instruction-fetch controller with sticky errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] target_addr,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] retired_cnt,
    output logic        err_misalign,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    // Counter value on the last unacknowledged FETCH cycle that is still allowed.
    localparam logic [7:0] c_TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic [7:0]  r_tcnt;
    logic        r_err_mis;
    logic        r_err_tmo;
    logic [31:0] w_pc_plus4;
    logic        w_target_misaligned;

    assign w_pc_plus4          = r_pc + 32'd4;
    assign w_target_misaligned = redirect && (target_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_retired <= 32'd0;
            r_tcnt    <= 8'd0;
            r_err_mis <= 1'b0;
            r_err_tmo <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    // A ready in the final allowed cycle takes priority over the timeout.
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_tcnt  <= 8'd0;
                        r_state <= S_EXEC;
                    end else if (r_tcnt == c_TMO_LAST) begin
                        r_err_tmo <= 1'b1;
                        r_state   <= S_ERR;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        if (w_target_misaligned) begin
                            r_err_mis <= 1'b1;
                            r_state   <= S_ERR;
                        end else begin
                            r_pc      <= redirect ? target_addr : w_pc_plus4;
                            r_retired <= r_retired + 32'd1;
                            r_state   <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_ERR;
                end
            endcase
        end
    end

    assign imem_req     = (r_state == S_FETCH);
    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign instr        = r_instr;
    assign instr_valid  = (r_state == S_EXEC);
    assign retired_cnt  = r_retired;
    assign err_misalign = r_err_mis;
    assign err_timeout  = r_err_tmo;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed and randomized checks of pc_fetch_unit against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    localparam logic [31:0] c_RPC = 32'h0000_0100;
    localparam int          c_TMO = 4;
    localparam int P_BOOT = 0, P_FETCH = 1, P_EXEC = 2, P_ERR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] target_addr = 32'd0;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] retired_cnt;
    logic        err_misalign;
    logic        err_timeout;

    pc_fetch_unit #(
        .RESET_PC      (c_RPC),
        .FETCH_TIMEOUT (c_TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .target_addr  (target_addr),
        .redirect     (redirect),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .retired_cnt  (retired_cnt),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: phase of the instruction life cycle, architectural PC/instr/count.
    int          m_phase;
    int          m_waits;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ret;
    logic        m_em;
    logic        m_et;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_BOOT;
        m_waits = 0;
        m_pc    = c_RPC;
        m_instr = 32'd0;
        m_ret   = 32'd0;
        m_em    = 1'b0;
        m_et    = 1'b0;
    endtask

    task automatic model_step();
        case (m_phase)
            P_BOOT: m_phase = P_FETCH;
            P_FETCH: begin
                if (imem_ready) begin
                    m_instr = imem_rdata;
                    m_waits = 0;
                    m_phase = P_EXEC;
                end else begin
                    m_waits = m_waits + 1;
                    if (m_waits >= c_TMO) begin
                        m_et    = 1'b1;
                        m_phase = P_ERR;
                    end
                end
            end
            P_EXEC: begin
                if (!stall) begin
                    if (redirect && (target_addr % 4 != 0)) begin
                        m_em    = 1'b1;
                        m_phase = P_ERR;
                    end else begin
                        m_pc    = redirect ? target_addr : m_pc + 32'd4;
                        m_ret   = m_ret + 32'd1;
                        m_phase = P_FETCH;
                    end
                end
            end
            default: m_phase = P_ERR;
        endcase
    endtask

    task automatic compare_model();
        chk("imem_req",     {31'd0, imem_req},     {31'd0, m_phase == P_FETCH});
        chk("imem_addr",    imem_addr,             m_pc);
        chk("pc",           pc,                    m_pc);
        chk("pc_plus4",     pc_plus4,              m_pc + 32'd4);
        chk("instr",        instr,                 m_instr);
        chk("instr_valid",  {31'd0, instr_valid},  {31'd0, m_phase == P_EXEC});
        chk("retired_cnt",  retired_cnt,           m_ret);
        chk("err_misalign", {31'd0, err_misalign}, {31'd0, m_em});
        chk("err_timeout",  {31'd0, err_timeout},  {31'd0, m_et});
    endtask

    // Called just after a falling edge; drives inputs for one full cycle.
    task automatic cyc(input logic rdy, input logic [31:0] data, input logic rd,
                       input logic [31:0] tgt, input logic st);
        imem_ready  = rdy;
        imem_rdata  = data;
        redirect    = rd;
        target_addr = tgt;
        stall       = st;
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Asserts reset between edges to confirm it acts without a clock.
    task automatic async_pulse();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_model();
        chk("async_req",  {31'd0, imem_req}, 32'd0);
        chk("async_pc",   pc, c_RPC);
        chk("async_errs", {30'd0, err_misalign, err_timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : main
        logic [31:0] t;
        logic        rdy, st, rd;

        model_reset();
        @(negedge clk);
        compare_model();
        chk("rst_pc",      pc, 32'h100);
        chk("rst_req",     {31'd0, imem_req}, 32'd0);
        chk("rst_instr",   instr, 32'd0);
        chk("rst_retired", retired_cnt, 32'd0);
        rst_n = 1'b1;

        // Back-to-back fetches with memory always ready.
        cyc(1'b1, 32'hA000_0000, 1'b0, 32'd0, 1'b0);
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h100);
        cyc(1'b1, 32'hA000_0001, 1'b0, 32'd0, 1'b0);
        chk("first_instr", instr, 32'hA000_0001);
        cyc(1'b1, 32'hA000_0002, 1'b0, 32'd0, 1'b0);
        chk("second_addr", imem_addr, 32'h104);
        cyc(1'b1, 32'hA000_0003, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'hA000_0004, 1'b0, 32'd0, 1'b0);
        chk("third_addr", imem_addr, 32'h108);
        cyc(1'b1, 32'hA000_0005, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'hA000_0006, 1'b0, 32'd0, 1'b0);
        chk("retired_3", retired_cnt, 32'd3);

        // Redirect at pc 0x104.
        @(negedge clk);
        do_reset();
        cyc(1'b1, 32'h0, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'h1, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'h2, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'h3, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'h4, 1'b1, 32'h40, 1'b0);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_ret",  retired_cnt, 32'd2);

        // Three wait states, ready on the last allowed cycle.
        cyc(1'b0, 32'h5, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 32'h6, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 32'h7, 1'b0, 32'd0, 1'b0);
        chk("wait_req", {31'd0, imem_req}, 32'd1);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
        chk("wait_instr", instr, 32'hDEAD_BEEF);
        chk("wait_noerr", {31'd0, err_timeout}, 32'd0);

        // Two stall cycles keep the instruction in EXEC.
        cyc(1'b1, 32'h8, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 32'h9, 1'b0, 32'd0, 1'b1);
        chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        chk("stall_pc",    pc, 32'h40);
        chk("stall_instr", instr, 32'hDEAD_BEEF);
        cyc(1'b1, 32'hA, 1'b0, 32'd0, 1'b0);
        chk("stall_done", {31'd0, instr_valid}, 32'd0);

        // Misaligned redirect at pc 0x44.
        cyc(1'b1, 32'hB, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'hC, 1'b1, 32'h42, 1'b0);
        chk("mis_flag", {31'd0, err_misalign}, 32'd1);
        chk("mis_pc",   pc, 32'h44);
        chk("mis_ret",  retired_cnt, 32'd3);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hD, 1'b0, 32'd0, 1'b0);
        chk("mis_req", {31'd0, imem_req}, 32'd0);

        // Fetch timeout after four unacknowledged cycles.
        @(negedge clk);
        do_reset();
        cyc(1'b0, 32'h0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'd0, 1'b0);
        chk("tmo_early", {31'd0, err_timeout}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 32'd0, 1'b0);
        chk("tmo_flag", {31'd0, err_timeout}, 32'd1);
        chk("tmo_req",  {31'd0, imem_req}, 32'd0);
        cyc(1'b1, 32'h0, 1'b0, 32'd0, 1'b0);

        // PC wrap from the top of the address space.
        @(negedge clk);
        do_reset();
        cyc(1'b1, 32'h0, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'h1, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'h2, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_p4",  pc_plus4, 32'h0);
        cyc(1'b1, 32'h3, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'h4, 1'b0, 32'h0000_0003, 1'b0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset pulse while a fetch is pending.
        cyc(1'b0, 32'h5, 1'b0, 32'd0, 1'b0);
        async_pulse();

        for (int i = 0; i < 3000; i++) begin
            if (m_phase == P_ERR && $urandom_range(0, 5) == 0) begin
                async_pulse();
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
                st  = ($urandom_range(0, 3) == 0);
                rd  = ($urandom_range(0, 2) == 0);
                t   = $urandom;
                if ($urandom_range(0, 19) != 0 || !rd) begin
                    if (rd) t[1:0] = 2'b00;
                end
                cyc(rdy, $urandom, rd, t, st);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
